// File: rtl/ysyx_25030085_pkg.sv
// Shared types and constants for the ysyx_25030085 instruction fetch unit.
// Holds the FSM state encoding, exception codes, the NOP word and the reset PC.
package ysyx_25030085_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } ifu_state_e;

  typedef enum logic [1:0] {
    EXC_NONE       = 2'b00,
    EXC_MISALIGNED = 2'b01,
    EXC_ACCESS     = 2'b10,
    EXC_TIMEOUT    = 2'b11
  } exc_e;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030085_timeout_cnt.sv
// Saturating 8-bit cycle counter for the fetch WAIT state.
// expired flags the TIMEOUT-th enabled cycle, i.e. the cycle in which the count reaches TIMEOUT.
module ysyx_25030085_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (enable && cnt != LIMIT) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = enable && (cnt >= LIMIT - 8'd1);

endmodule

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: PC handshake in, one memory read per fetch, instruction held for decode.
// Flushed fetches still complete their bus transaction but their result is dropped.
module ysyx_25030085_ifu
  import ysyx_25030085_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  exc
);

  ifu_state_e  state;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  exc_e        exc_q;
  logic        drop_q;
  logic        handshake;
  logic        expired;

  assign pc_ready  = !flush && (state == S_IDLE || (state == S_HOLD && inst_ready));
  assign handshake = pc_valid && pc_ready;

  ysyx_25030085_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == S_REQ && imem_req_ready),
    .enable (state == S_WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= RESET_PC;
      inst_q <= NOP;
      exc_q  <= EXC_NONE;
      drop_q <= 1'b0;
    end else if (handshake) begin
      // A handshake is only possible from IDLE or from HOLD while decode consumes.
      addr_q <= pc;
      if (pc[1:0] == 2'b00) begin
        state <= S_REQ;
      end else begin
        state  <= S_HOLD;
        inst_q <= NOP;
        exc_q  <= EXC_MISALIGNED;
      end
    end else begin
      unique case (state)
        S_IDLE: ;
        S_REQ: begin
          if (flush) drop_q <= 1'b1;
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid || expired) begin
            drop_q <= 1'b0;
            if (drop_q || flush) begin
              state <= S_IDLE;
            end else begin
              state <= S_HOLD;
              if (imem_rsp_valid) begin
                inst_q <= imem_rsp_data;
                exc_q  <= imem_rsp_err ? EXC_ACCESS : EXC_NONE;
              end else begin
                inst_q <= NOP;
                exc_q  <= EXC_TIMEOUT;
              end
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: if (flush || inst_ready) state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = addr_q;
  assign inst_valid     = (state == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = addr_q;
  assign exc            = exc_q;

endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Self-checking bench for ysyx_25030085_ifu: vector table plus hand sequences for flush/reset,
// with a behavioural instruction memory and a scoreboard queue of expected fetch results.
module tb_ysyx_25030085_ifu;
  import ysyx_25030085_pkg::*;

  typedef struct {
    logic [31:0] pc;
    int          stall;
    int          delay;
    bit          no_rsp;
    logic [31:0] data;
    bit          err;
    logic [31:0] exp_inst;
    logic [1:0]  exp_exc;
    int          exp_lat;
    int          exp_reqs;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  exc;

  ysyx_25030085_ifu #(.TIMEOUT(255)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .flush         (flush),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .exc           (exc)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Memory model configuration, set by the stimulus before each fetch.
  int          cfg_stall  = 0;
  int          cfg_delay  = 0;
  bit          cfg_no_rsp = 1'b0;
  logic [31:0] cfg_data   = 32'h0;
  bit          cfg_err    = 1'b0;
  logic [31:0] exp_addr   = 32'h0;
  int          n_accepts  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int stall, input int delay, input bit no_rsp,
                         input logic [31:0] data, input bit err);
    cfg_stall  = stall;
    cfg_delay  = delay;
    cfg_no_rsp = no_rsp;
    cfg_data   = data;
    cfg_err    = err;
  endtask

  // Memory model: stalls the request, checks address stability, returns one response per accept.
  initial begin
    bit last_req   = 1'b0;
    bit pending    = 1'b0;
    int delay_left = 0;
    int stall_left = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (last_req && imem_req_ready) begin
        n_accepts++;
        if (!cfg_no_rsp) begin
          pending    = 1'b1;
          delay_left = cfg_delay;
        end
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      if (pending) begin
        if (delay_left == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = cfg_data;
          imem_rsp_err   = cfg_err;
          pending        = 1'b0;
        end else begin
          delay_left--;
        end
      end
      if (imem_req_valid && !last_req) stall_left = cfg_stall;
      if (imem_req_valid) check("imem_addr_stable", imem_addr, exp_addr);
      last_req = imem_req_valid;
      if (imem_req_valid && stall_left == 0) begin
        imem_req_ready = 1'b1;
      end else begin
        imem_req_ready = 1'b0;
        if (imem_req_valid) stall_left--;
      end
    end
  end

  task automatic start_fetch(input logic [31:0] a, input bit push, input logic [31:0] inst_e,
                             input logic [1:0] exc_e, output bit ok);
    int tries = 0;
    pc       = a;
    pc_valid = 1'b1;
    exp_addr = a;
    #1;
    while (!pc_ready && tries < 20) begin
      tick();
      #1;
      tries++;
    end
    ok = pc_ready;
    check("pc_ready", pc_ready, 1);
    if (ok && push) sb.push_back('{a, inst_e, exc_e});
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat);
    int   cyc = 1;
    exp_t e;
    #1;
    while (!inst_valid && cyc < 400) begin
      tick();
      #1;
      cyc++;
    end
    check("inst_valid", inst_valid, 1);
    check("latency", cyc, exp_lat);
    if (sb.size() == 0) begin
      check("scoreboard_has_entry", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check("inst", inst, e.inst);
      check("inst_pc", inst_pc, e.pc);
      check("exc", exc, e.exc);
    end
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    check("inst_valid_after_ack", inst_valid, 0);
  endtask

  task automatic watch_no_valid(input int n, input string name);
    bit saw = 1'b0;
    repeat (n) begin
      #1;
      saw |= inst_valid;
      tick();
    end
    check(name, saw, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    bit   ok;
    int   acc0;

    vecs[0] = '{32'h8000_0000, 0, 0, 1'b0, 32'h0010_0093, 1'b0, 32'h0010_0093, 2'b00, 3,   1};
    vecs[1] = '{32'h8000_0002, 0, 0, 1'b0, 32'h1111_1111, 1'b0, 32'h0000_0013, 2'b01, 1,   0};
    vecs[2] = '{32'h8000_0001, 0, 0, 1'b0, 32'h2222_2222, 1'b0, 32'h0000_0013, 2'b01, 1,   0};
    vecs[3] = '{32'h8000_0008, 4, 0, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678, 2'b00, 7,   1};
    vecs[4] = '{32'h8000_000C, 0, 2, 1'b0, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE, 2'b10, 5,   1};
    vecs[5] = '{32'h8000_0010, 1, 0, 1'b1, 32'h3333_3333, 1'b0, 32'h0000_0013, 2'b11, 258, 1};
    vecs[6] = '{32'h0000_0004, 0, 3, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 2'b00, 6,   1};

    rst_n      = 1'b0;
    pc         = 32'h0;
    pc_valid   = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b0;
    tick();
    #1;
    check("rst_imem_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_imem_addr", imem_addr, 32'h8000_0000);
    check("rst_inst_pc", inst_pc, 32'h8000_0000);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_exc", exc, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      set_cfg(vecs[i].stall, vecs[i].delay, vecs[i].no_rsp, vecs[i].data, vecs[i].err);
      acc0 = n_accepts;
      start_fetch(vecs[i].pc, 1'b1, vecs[i].exp_inst, vecs[i].exp_exc, ok);
      if (ok) begin
        wait_out(vecs[i].exp_lat);
        tick();
        #1;
        check("hold_stable_inst", inst, vecs[i].exp_inst);
        check("hold_stable_exc", exc, vecs[i].exp_exc);
        consume();
      end
      tick();
      check("request_count", n_accepts - acc0, vecs[i].exp_reqs);
    end

    // Flush while waiting for the response; the late word must be dropped.
    set_cfg(0, 2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    start_fetch(32'h8000_0020, 1'b0, 32'h0, 2'b00, ok);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    watch_no_valid(6, "flush_wait_no_valid");
    #1;
    check("flush_wait_pc_ready", pc_ready, 1);
    check("flush_wait_no_req", imem_req_valid, 0);
    tick();

    // Flush during a stalled request: the request stays up until accepted.
    set_cfg(2, 0, 1'b0, 32'h4444_4444, 1'b0);
    start_fetch(32'h8000_0024, 1'b0, 32'h0, 2'b00, ok);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_req_still_valid", imem_req_valid, 1);
    check("flush_req_addr", imem_addr, 32'h8000_0024);
    tick();
    watch_no_valid(6, "flush_req_no_valid");
    #1;
    check("flush_req_pc_ready", pc_ready, 1);
    tick();

    // Flush in the same cycle the response arrives.
    set_cfg(0, 1, 1'b0, 32'h5555_5555, 1'b0);
    start_fetch(32'h8000_0028, 1'b0, 32'h0, 2'b00, ok);
    tick();
    tick();
    #1;
    check("same_cycle_rsp_present", imem_rsp_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    watch_no_valid(4, "same_cycle_flush_no_valid");

    // Flush in HOLD blocks a concurrent handshake and empties the stage.
    start_fetch(32'h8000_0003, 1'b1, 32'h0000_0013, 2'b01, ok);
    wait_out(1);
    pc         = 32'h8000_0030;
    pc_valid   = 1'b1;
    inst_ready = 1'b1;
    flush      = 1'b1;
    #1;
    check("flush_hold_pc_ready", pc_ready, 0);
    tick();
    flush      = 1'b0;
    pc_valid   = 1'b0;
    inst_ready = 1'b0;
    #1;
    check("flush_hold_inst_valid", inst_valid, 0);
    check("flush_hold_no_req", imem_req_valid, 0);
    check("flush_hold_idle_ready", pc_ready, 1);
    tick();

    // Back-to-back fetch: new PC accepted in the same cycle the held word is consumed.
    set_cfg(0, 0, 1'b0, 32'h0010_0093, 1'b0);
    start_fetch(32'h8000_0000, 1'b1, 32'h0010_0093, 2'b00, ok);
    wait_out(3);
    cfg_data   = 32'h0020_8113;
    pc         = 32'h8000_0004;
    pc_valid   = 1'b1;
    inst_ready = 1'b1;
    exp_addr   = 32'h8000_0004;
    #1;
    check("b2b_pc_ready", pc_ready, 1);
    sb.push_back('{32'h8000_0004, 32'h0020_8113, 2'b00});
    tick();
    pc_valid   = 1'b0;
    inst_ready = 1'b0;
    #1;
    check("b2b_req_valid", imem_req_valid, 1);
    check("b2b_req_addr", imem_addr, 32'h8000_0004);
    check("b2b_inst_valid_low", inst_valid, 0);
    wait_out(3);
    consume();
    tick();

    // Asynchronous reset in WAIT; the response arriving after release is ignored.
    set_cfg(0, 3, 1'b0, 32'h0BAD_F00D, 1'b0);
    start_fetch(32'h8000_0038, 1'b0, 32'h0, 2'b00, ok);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", imem_req_valid, 0);
    check("midrst_inst_valid", inst_valid, 0);
    check("midrst_imem_addr", imem_addr, 32'h8000_0000);
    check("midrst_inst_pc", inst_pc, 32'h8000_0000);
    check("midrst_inst", inst, 32'h0000_0013);
    check("midrst_exc", exc, 0);
    tick();
    rst_n = 1'b1;
    watch_no_valid(6, "post_reset_rsp_ignored");
    #1;
    check("post_reset_pc_ready", pc_ready, 1);
    tick();

    set_cfg(0, 0, 1'b0, 32'h0000_0073, 1'b0);
    start_fetch(32'h8000_0040, 1'b1, 32'h0000_0073, 2'b00, ok);
    if (ok) begin
      wait_out(3);
      consume();
    end
    tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
